urand_pair_gen: RTL and testbench
=================================

# urand_pair_gen

Source block for the Box-Muller Gaussian pipeline: produces pairs of uniformly distributed IEEE-754 double-precision values U1, U2 in the open interval (0,1). It uses two independent xorshift64 generators and an exact integer-to-double normalizer. It drives the transform stage's pushin/U1/U2 inputs one pair per cycle, in bursts of a programmed length, with no backpressure.

## Interface
- SEED1, 64'h0123_4567_89AB_CDEF, reset/default state of U1 generator
- SEED2, 64'hFEDC_BA98_7654_3210, reset/default state of U2 generator
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- seed_load  in  1  load seed1/seed2 into generator states (IDLE only)
- seed1  in  64  U1 generator seed
- seed2  in  64  U2 generator seed
- start  in  1  begin a burst (IDLE only)
- count  in  16  number of pairs in burst, sampled with start
- busy  out  1  high from start acceptance until last pair emitted
- done  out  1  one-cycle pulse coincident with last pushout of a burst
- pushout  out  1  U1/U2 valid this cycle
- U1  out  64  uniform double, (0,1)
- U2  out  64  uniform double, (0,1)

## Operation
- FSM states: IDLE, RUN, DRAIN.
  - IDLE: start=1 with count≠0 → RUN; load remaining counter = count.
  - IDLE: start=1 with count=0 → stay IDLE; done pulses 2 cycles later; no pushout.
  - RUN: each cycle both generators advance once and a stage-1 valid flag is set. Counter decrements; at 1 → DRAIN.
  - DRAIN: one cycle, flushing the conversion stage → IDLE.
- start or seed_load while busy: ignored. seed_load and start in the same IDLE cycle: seed is loaded first, and the burst uses the new seed.
- Seed value 0 is illegal for xorshift. A loaded 0 is replaced by the corresponding SEED parameter.
- Generator step, 64-bit: x ^= x<<13; x ^= x>>7; x ^= x<<17.
- Conversion, identical for U1 and U2:
  - r = x[52:0]; if r==0, r = 1.
  - p = index of leading one of r (0..52).
  - sign = 0; exponent = 970+p; mantissa = (r << (52−p))[51:0].
  - Result is exactly r·2^-53. It is never 0 or 1, so downstream ln() is safe.
- Generator state persists across bursts; a new burst continues the sequence.

## Timing
- Reset values: busy=0, done=0, pushout=0, U1=0, U2=0, FSM=IDLE, generator states = SEED1/SEED2, counter=0.
- Pipeline: start sampled at edge T. The first advanced state is registered at edge T+1. Converted U1/U2 and pushout are registered at edge T+2.
- Latency from start to first pushout: 2 cycles.
- pushout is high for exactly count consecutive cycles. done is high in the same cycle as the final pushout.
- busy rises at edge T+1 and falls at the edge after the final pushout. A new start is accepted in the cycle busy is low; back-to-back bursts therefore have a gap of ≥1 cycle.
- U1/U2 hold their last value while pushout=0.
- rst mid-burst: on the next edge all outputs and state return to reset values, and any in-flight pair is discarded (no pushout).

## Test plan
- Reset then idle 10 cycles → pushout=0, busy=0, U1=U2=0 throughout.
- seed_load with seed1=seed2=1, then start with count=1 → pushout exactly 2 cycles after start; U1=U2=64'h3E80208810400000 (state 0x40822041, p=30); done in the same cycle.
- seed_load with seed1=0 → behaves as SEED1. The first U1 matches a reference model seeded with 64'h0123456789ABCDEF.
- start with count=5 → 5 consecutive pushout cycles. Every U1/U2 matches the software xorshift+conversion model. Every value has sign 0 and exponent field in [970,1022].
- start with count=0 → no pushout; single done pulse; busy stays 0. A start issued during a count=4 burst is ignored: total pushouts = 4.
- Assert rst during the 3rd pair of a count=10 burst → no further pushout. Outputs are 0 next cycle. A following seed_load(1,1)+start(count=1) reproduces 64'h3E80208810400000.

Source files
------------

// File: rtl/urand_pair_gen.sv
// Uniform (0,1) double pair source for the Box-Muller pipeline.
// Two xorshift64 generators feed an exact integer-to-double stage.
module urand_pair_gen #(
   parameter logic [63:0] SEED1 = 64'h0123_4567_89AB_CDEF,
   parameter logic [63:0] SEED2 = 64'hFEDC_BA98_7654_3210
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        seed_load,
   input  logic [63:0] seed1,
   input  logic [63:0] seed2,
   input  logic        start,
   input  logic [15:0] count,
   output logic        busy,
   output logic        done,
   output logic        pushout,
   output logic [63:0] U1,
   output logic [63:0] U2
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t      state_q;
   logic [15:0] cnt_q;
   logic [63:0] x1_q, x2_q;
   logic        v1_q;
   logic        zd0_q, zd1_q;
   logic        busy_q, done_q, push_q;
   logic [63:0] u1_q, u2_q;

   logic        accept;
   logic [63:0] x1_d, x2_d;
   logic [63:0] s1_d, s2_d;
   logic [63:0] u1_d, u2_d;

   function automatic logic [63:0] step(input logic [63:0] x);
      logic [63:0] y;
      y = x ^ (x << 13);
      y = y ^ (y >> 7);
      y = y ^ (y << 17);
      return y;
   endfunction

   // r * 2^-53 with r = x[52:0] (0 mapped to 1): exact, never 0 or 1
   function automatic logic [63:0] conv(input logic [63:0] x);
      logic [52:0] r;
      logic [52:0] sh;
      logic [5:0]  p;
      logic [10:0] e;
      r = x[52:0];
      if (r == '0) r = 53'd1;
      p = '0;
      for (int i = 0; i < 53; i++)
         if (r[i]) p = 6'(i);
      sh = r << (6'd52 - p);
      e  = 11'd970 + 11'(p);
      return {1'b0, e, sh[51:0]};
   endfunction

   // Next-state helpers: seed sanitising, generator step, conversion
   always_comb begin
      accept = (state_q == IDLE) && !busy_q;
      s1_d   = (seed1 == '0) ? SEED1 : seed1;
      s2_d   = (seed2 == '0) ? SEED2 : seed2;
      x1_d   = step(x1_q);
      x2_d   = step(x2_q);
      u1_d   = conv(x1_q);
      u2_d   = conv(x2_q);
   end

   // Burst FSM, generator states and registered conversion stage
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         x1_q    <= SEED1;
         x2_q    <= SEED2;
         v1_q    <= 1'b0;
         zd0_q   <= 1'b0;
         zd1_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         push_q  <= 1'b0;
         u1_q    <= '0;
         u2_q    <= '0;
      end else begin
         busy_q <= (state_q != IDLE);
         push_q <= v1_q;
         done_q <= zd1_q | (state_q == DRAIN);
         zd1_q  <= zd0_q;
         zd0_q  <= 1'b0;
         v1_q   <= 1'b0;
         if (v1_q) begin
            u1_q <= u1_d;
            u2_q <= u2_d;
         end
         unique case (state_q)
            IDLE: begin
               if (accept && seed_load) begin
                  x1_q <= s1_d;
                  x2_q <= s2_d;
               end
               if (accept && start) begin
                  if (count != '0) begin
                     state_q <= RUN;
                     cnt_q   <= count;
                  end else begin
                     zd0_q <= 1'b1;
                  end
               end
            end
            RUN: begin
               x1_q  <= x1_d;
               x2_q  <= x2_d;
               v1_q  <= 1'b1;
               cnt_q <= cnt_q - 16'd1;
               if (cnt_q == 16'd1) state_q <= DRAIN;
            end
            DRAIN: state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign pushout = push_q;
   assign U1      = u1_q;
   assign U2      = u2_q;

endmodule

// File: tb/tb_urand_pair_gen.sv
// Directed bench for urand_pair_gen.
// Expected values come from constants and a small software model.
module tb_urand_pair_gen;

   localparam logic [63:0] S1 = 64'h0123_4567_89AB_CDEF;
   localparam logic [63:0] S2 = 64'hFEDC_BA98_7654_3210;
   localparam logic [63:0] K1 = 64'h3E80208810400000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        seed_load = 1'b0;
   logic [63:0] seed1 = '0;
   logic [63:0] seed2 = '0;
   logic        start = 1'b0;
   logic [15:0] count = '0;
   logic        busy, done, pushout;
   logic [63:0] U1, U2;

   int checks = 0;
   int errors = 0;
   logic [63:0] m1, m2;

   urand_pair_gen dut (
      .clk(clk), .rst(rst),
      .seed_load(seed_load), .seed1(seed1), .seed2(seed2),
      .start(start), .count(count),
      .busy(busy), .done(done), .pushout(pushout),
      .U1(U1), .U2(U2)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] mstep(input logic [63:0] x);
      logic [63:0] y;
      y = x ^ (x << 13);
      y = y ^ (y >> 7);
      y = y ^ (y << 17);
      return y;
   endfunction

   // normalise by shifting the leading one up to bit 52
   function automatic logic [63:0] mconv(input logic [63:0] x);
      logic [52:0] m;
      int sh;
      m = x[52:0];
      if (m == '0) m = 53'd1;
      sh = 0;
      while (!m[52]) begin
         m = m << 1;
         sh++;
      end
      return {1'b0, 11'(1022 - sh), m[51:0]};
   endfunction

   function automatic real mreal(input logic [63:0] x);
      logic [52:0] r;
      r = x[52:0];
      if (r == '0) r = 53'd1;
      return real'(r) / 9007199254740992.0;
   endfunction

   task automatic check_val(input string tag, input logic [63:0] v,
                            input logic [63:0] st);
      logic [10:0] e;
      chk(tag, v, mconv(st));
      e = v[62:52];
      chk({tag, "_sign"}, 64'(v[63]), 64'd0);
      chk({tag, "_exprng"}, 64'(e >= 11'd970 && e <= 11'd1022), 64'd1);
      chk({tag, "_real"}, 64'($bitstoreal(v) == mreal(st)), 64'd1);
   endtask

   task automatic burst(input logic [15:0] n, input bit poke);
      int first;
      int last;
      int np;
      int nd;
      first = -1;
      last  = -1;
      np    = 0;
      nd    = 0;
      start = 1'b1;
      count = n;
      tick();
      start     = 1'b0;
      count     = '0;
      seed_load = 1'b0;
      for (int i = 1; i <= int'(n) + 6; i++) begin
         if (poke && i == 3) begin
            start = 1'b1;
            count = 16'd3;
         end
         if (poke && i == 4) begin
            start = 1'b0;
            count = '0;
         end
         tick();
         if (i == 1) chk("busy_rise", 64'(busy), 64'd1);
         if (done) nd++;
         if (pushout) begin
            np++;
            if (first < 0) first = i;
            last = i;
            m1 = mstep(m1);
            m2 = mstep(m2);
            check_val("u1", U1, m1);
            check_val("u2", U2, m2);
            chk("done_last", 64'(done), 64'(np == int'(n)));
         end
      end
      chk("first_lat", 64'(first), 64'd2);
      chk("npush", 64'(np), 64'(n));
      chk("last_idx", 64'(last), 64'(int'(n) + 1));
      chk("ndone", 64'(nd), 64'd1);
      chk("busy_end", 64'(busy), 64'd0);
   endtask

   initial begin
      int np;
      int nd;
      int di;
      int bh;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_push", 64'(pushout), 64'd0);
      chk("rst_u1", U1, 64'd0);
      chk("rst_u2", U2, 64'd0);
      np = 0;
      bh = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (pushout) np++;
         if (busy) bh++;
         if (U1 != '0 || U2 != '0) bh++;
      end
      chk("idle_push", 64'(np), 64'd0);
      chk("idle_busy_u", 64'(bh), 64'd0);

      // seed 1/1, single pair
      seed_load = 1'b1;
      seed1 = 64'd1;
      seed2 = 64'd1;
      m1 = 64'd1;
      m2 = 64'd1;
      burst(16'd1, 1'b0);
      chk("k1_u1", U1, K1);
      chk("k1_u2", U2, K1);

      // zero seed1 replaced by default, seed2 arbitrary
      seed_load = 1'b1;
      seed1 = 64'd0;
      seed2 = 64'd5;
      m1 = S1;
      m2 = 64'd5;
      burst(16'd1, 1'b0);
      chk("seed0_u1", U1, mconv(mstep(S1)));

      // five pairs continuing the sequence
      burst(16'd5, 1'b0);

      // count=0: lone done pulse, no pushout, no busy
      start = 1'b1;
      count = '0;
      tick();
      start = 1'b0;
      np = 0;
      nd = 0;
      di = -1;
      bh = 0;
      for (int i = 1; i <= 5; i++) begin
         tick();
         if (pushout) np++;
         if (done) begin
            nd++;
            di = i;
         end
         if (busy) bh++;
      end
      chk("z_push", 64'(np), 64'd0);
      chk("z_ndone", 64'(nd), 64'd1);
      chk("z_done_at", 64'(di), 64'd2);
      chk("z_busy", 64'(bh), 64'd0);

      // start while busy is ignored
      burst(16'd4, 1'b1);

      // reset during third pair of a ten-pair burst
      start = 1'b1;
      count = 16'd10;
      tick();
      start = 1'b0;
      count = '0;
      for (int i = 1; i <= 4; i++) tick();
      chk("mid_push3", 64'(pushout), 64'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mr_push", 64'(pushout), 64'd0);
      chk("mr_busy", 64'(busy), 64'd0);
      chk("mr_done", 64'(done), 64'd0);
      chk("mr_u1", U1, 64'd0);
      chk("mr_u2", U2, 64'd0);
      np = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (pushout) np++;
      end
      chk("mr_nopush", 64'(np), 64'd0);
      seed_load = 1'b1;
      seed1 = 64'd1;
      seed2 = 64'd1;
      m1 = 64'd1;
      m2 = 64'd1;
      burst(16'd1, 1'b0);
      chk("mr_k1_u1", U1, K1);
      chk("mr_k1_u2", U2, K1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
